// File: rtl/txbuf_dma_seq.sv
// txbuf_dma_seq: runs one DELQA transmit job through the 1K-word buffer.
// Q-bus words go into the buffer, the buffer goes to Ethernet, then back to Wishbone.
module txbuf_dma_seq #(
   parameter int AW = 10,
   parameter int LW = 11
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          start_i,
   input  logic [LW-1:0] len_i,
   input  logic          abort_i,
   output logic          qdma_req_o,
   input  logic          qdma_ack_i,
   input  logic [15:0]   qdma_dat_i,
   input  logic          qdma_err_i,
   output logic          dma_stb_o,
   output logic          dma_we_o,
   output logic [AW-1:0] dma_adr_o,
   output logic [15:0]   dma_dat_o,
   output logic [1:0]    adr_mode_o,
   output logic          eth_start_o,
   output logic [LW-1:0] eth_len_o,
   input  logic          eth_done_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_GUARD_D = 3'd1;
   localparam logic [2:0] S_REQ     = 3'd2;
   localparam logic [2:0] S_WRITE   = 3'd3;
   localparam logic [2:0] S_GUARD_E = 3'd4;
   localparam logic [2:0] S_SEND    = 3'd5;
   localparam logic [2:0] S_WAIT    = 3'd6;

   localparam logic [LW-1:0] MAX_LEN = LW'(1 << AW);

   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic [1:0]    mode_nxt;
   logic [LW-1:0] cnt;
   logic          done_nxt;
   logic          err_set;
   logic          start_ok;
   logic          cap;

   assign qdma_req_o = (state == S_REQ);

   // Abort overrides every other event, including a word acked this cycle.
   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      err_set   = 1'b0;
      start_ok  = 1'b0;
      cap       = 1'b0;
      if (state != S_IDLE && abort_i) begin
         state_nxt = S_IDLE;
         done_nxt  = 1'b1;
         err_set   = 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  if (len_i != '0 && len_i <= MAX_LEN) begin
                     start_ok  = 1'b1;
                     state_nxt = S_GUARD_D;
                  end else begin
                     done_nxt = 1'b1;
                     err_set  = 1'b1;
                  end
               end
            end
            S_GUARD_D: state_nxt = S_REQ;
            S_REQ: begin
               if (qdma_err_i) begin
                  state_nxt = S_IDLE;
                  done_nxt  = 1'b1;
                  err_set   = 1'b1;
               end else if (qdma_ack_i) begin
                  cap       = 1'b1;
                  state_nxt = S_WRITE;
               end
            end
            S_WRITE:   state_nxt = (cnt == eth_len_o) ? S_GUARD_E : S_REQ;
            S_GUARD_E: state_nxt = S_SEND;
            S_SEND:    state_nxt = S_WAIT;
            S_WAIT: begin
               if (eth_done_i) begin
                  state_nxt = S_IDLE;
                  done_nxt  = 1'b1;
               end
            end
            default:   state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      mode_nxt = 2'b00;
      case (state_nxt)
         S_GUARD_D, S_REQ, S_WRITE: mode_nxt = 2'b01;
         S_GUARD_E, S_SEND, S_WAIT: mode_nxt = 2'b10;
         default:                   mode_nxt = 2'b00;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state       <= S_IDLE;
         cnt         <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         adr_mode_o  <= 2'b00;
         dma_stb_o   <= 1'b0;
         dma_we_o    <= 1'b0;
         dma_adr_o   <= '0;
         dma_dat_o   <= '0;
         eth_start_o <= 1'b0;
         eth_len_o   <= '0;
      end else begin
         state       <= state_nxt;
         busy_o      <= (state_nxt != S_IDLE);
         done_o      <= done_nxt;
         adr_mode_o  <= mode_nxt;
         dma_stb_o   <= (state_nxt == S_WRITE);
         dma_we_o    <= (state_nxt == S_WRITE);
         eth_start_o <= (state_nxt == S_SEND);
         if (start_ok) begin
            eth_len_o <= len_i;
            cnt       <= '0;
            err_o     <= 1'b0;
         end
         if (err_set)
            err_o <= 1'b1;
         if (cap) begin
            dma_dat_o <= qdma_dat_i;
            dma_adr_o <= cnt[AW-1:0];
            cnt       <= cnt + LW'(1);
         end
      end
   end

endmodule
